ppu_vram_arbiter: RTL and testbench

PPU_VRAM_ARBITER -- requirements
Module: ppu_vram_arbiter

---
 rtl/ppu_vram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
//   Sits between the CPU-side PPU register window and the single-port PPU
//   VRAM. CPU writes to $7 are queued, tagged with the current VRAM address,
//   and drained to RAM only in cycles where the renderer is not reading.
//   The renderer has strict priority and gets its data one cycle after grant.
//
// Parameters
//   FIFO_DEPTH  depth of the CPU write queue (power of two, 2..32)
//
// Ports
//   clk_ppu    PPU clock, all logic on rising edge
//   rst_n      synchronous active-low reset
//   cpu_wr     CPU write strobe to register window
//   cpu_rd     CPU read strobe to register window
//   cpu_reg    register select $0-$7
//   cpu_data   CPU write data
//   ren_req    renderer VRAM read request
//   ren_addr   renderer read address
//   ren_data   read data returned to renderer (0 when not valid)
//   ren_valid  ren_data valid strobe
//   ram_addr   VRAM address
//   ram_we     VRAM write enable
//   ram_wdata  VRAM write data
//   ram_rdata  VRAM read data, one-cycle latency
//   cpu_full   write queue full
//   idle       write queue empty
//   drop_cnt   number of $7 writes dropped because the queue was full
//
// Build option
//   VRAM_ARB_DROP_CNT_EN  when defined, drop_cnt is a saturating counter;
//                         otherwise drop_cnt is tied to zero.

module ppu_vram_arbiter #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_ppu,
  input  logic        rst_n,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [2:0]  cpu_reg,
  input  logic [7:0]  cpu_data,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic [7:0]  ren_data,
  output logic        ren_valid,
  output logic [13:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        cpu_full,
  output logic        idle,
  output logic [7:0]  drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  // Each entry is {vram address, data}, captured at enqueue time so later
  // address changes never affect queued writes.
  logic [21:0]   q_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;

  logic [13:0] vaddr_reg;
  logic        w_reg;
  logic        inc32_reg;
  logic        ren_valid_reg;

  logic q_full;
  logic q_empty;
  logic wr7;
  logic enq;
  logic deq;
  logic [21:0] head;

  assign q_full  = (count_reg == DEPTH_C);
  assign q_empty = (count_reg == '0);
  assign wr7     = cpu_wr && (cpu_reg == 3'd7);
  // Full test uses the registered count: a same-cycle dequeue does not
  // make room for a write arriving while full.
  assign enq     = wr7 && !q_full;
  assign deq     = rst_n && !ren_req && !q_empty;
  assign head    = q_mem[rd_ptr_reg];

  assign cpu_full = q_full;
  assign idle     = q_empty;

  // Combinational arbitration; forced quiet while reset is asserted.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = 14'd0;
    ram_wdata = 8'd0;
    if (rst_n) begin
      if (ren_req) begin
        ram_addr = ren_addr;
      end else if (!q_empty) begin
        ram_we    = 1'b1;
        ram_addr  = head[21:8];
        ram_wdata = head[7:0];
      end
    end
  end

  // RAM latency is one cycle, so the read data lines up with the delayed
  // grant and can be passed straight through.
  assign ren_valid = ren_valid_reg;
  assign ren_data  = ren_valid_reg ? ram_rdata : 8'd0;

  always_ff @(posedge clk_ppu) begin
    if (enq) begin
      q_mem[wr_ptr_reg] <= {vaddr_reg, cpu_data};
    end
  end

  always_ff @(posedge clk_ppu) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      vaddr_reg     <= 14'd0;
      w_reg         <= 1'b0;
      inc32_reg     <= 1'b0;
      ren_valid_reg <= 1'b0;
    end else begin
      ren_valid_reg <= ren_req;

      // Pointers wrap naturally because the depth is a power of two.
      if (enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      if (cpu_wr) begin
        case (cpu_reg)
          3'd0: inc32_reg <= cpu_data[2];
          3'd6: begin
            if (!w_reg) vaddr_reg[13:8] <= cpu_data[5:0];
            else        vaddr_reg[7:0]  <= cpu_data;
            w_reg <= !w_reg;
          end
          3'd7: begin
            if (enq) vaddr_reg <= vaddr_reg + (inc32_reg ? 14'd32 : 14'd1);
          end
          default: ;
        endcase
      end else if (cpu_rd && (cpu_reg == 3'd2)) begin
        // Status read resets the address-latch toggle.
        w_reg <= 1'b0;
      end
    end
  end

`ifdef VRAM_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk_ppu) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else if (wr7 && q_full && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
module tb_ppu_vram_arbiter;

  localparam int D = 8;

  logic        clk_ppu = 1'b0;
  logic        rst_n;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_data;
  logic        ren_req;
  logic [13:0] ren_addr;
  logic [7:0]  ren_data;
  logic        ren_valid;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        cpu_full;
  logic        idle;
  logic [7:0]  drop_cnt;

  ppu_vram_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk_ppu   (clk_ppu),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_reg   (cpu_reg),
    .cpu_data  (cpu_data),
    .ren_req   (ren_req),
    .ren_addr  (ren_addr),
    .ren_data  (ren_data),
    .ren_valid (ren_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cpu_full  (cpu_full),
    .idle      (idle),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_ppu = ~clk_ppu;

  // VRAM stand-in: fixed random contents, one-cycle read latency.
  logic [7:0] ram_mem [0:16383];
  always @(posedge clk_ppu) ram_rdata <= ram_mem[ram_addr];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [21:0] mq[$];
  logic [13:0] m_vaddr = 14'd0;
  bit          m_w = 1'b0;
  bit          m_inc32 = 1'b0;
  int          m_drops = 0;
  bit          m_gnt = 1'b0;
  logic [7:0]  m_rdata = 8'd0;

  always @(negedge clk_ppu) begin
    bit          e_we;
    logic [13:0] e_addr;
    logic [7:0]  e_wdata;
    int          e_drop;
    bit          was_full;
    e_we = 1'b0; e_addr = 14'd0; e_wdata = 8'd0;
    if (rst_n) begin
      if (ren_req) e_addr = ren_addr;
      else if (mq.size() > 0) begin
        e_we = 1'b1; e_addr = mq[0][21:8]; e_wdata = mq[0][7:0];
      end
    end
`ifdef VRAM_ARB_DROP_CNT_EN
    e_drop = m_drops;
`else
    e_drop = 0;
`endif
    if (chk_en) begin
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      chk("ren_valid", 32'(ren_valid), 32'(m_gnt));
      chk("ren_data", 32'(ren_data), m_gnt ? 32'(m_rdata) : 32'd0);
      chk("cpu_full", 32'(cpu_full), 32'(mq.size() == D));
      chk("idle", 32'(idle), 32'(mq.size() == 0));
      chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    end
    // advance model to the state after the coming rising edge
    if (!rst_n) begin
      mq.delete(); m_vaddr = 0; m_w = 0; m_inc32 = 0; m_drops = 0; m_gnt = 0;
    end else begin
      was_full = (mq.size() == D);
      m_gnt = ren_req;
      if (ren_req) m_rdata = ram_mem[ren_addr];
      if (e_we) void'(mq.pop_front());
      if (cpu_wr) begin
        if (cpu_reg == 3'd0) m_inc32 = cpu_data[2];
        else if (cpu_reg == 3'd6) begin
          if (!m_w) m_vaddr[13:8] = cpu_data[5:0];
          else      m_vaddr[7:0]  = cpu_data;
          m_w = !m_w;
        end else if (cpu_reg == 3'd7) begin
          if (was_full) begin
            if (m_drops < 255) m_drops++;
          end else begin
            mq.push_back({m_vaddr, cpu_data});
            m_vaddr = 14'((int'(m_vaddr) + (m_inc32 ? 32 : 1)) % 16384);
          end
        end
      end else if (cpu_rd && cpu_reg == 3'd2) begin
        m_w = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk_ppu); #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    $display("wr reg=%0d data=%h ren_req=%0b", r, d, ren_req);
    cpu_wr = 1'b1; cpu_reg = r; cpu_data = d;
    sync();
    cpu_wr = 1'b0;
  endtask

  task automatic rd2();
    $display("rd reg=2");
    cpu_rd = 1'b1; cpu_reg = 3'd2;
    sync();
    cpu_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram_mem[i] = 8'($urandom);
    rst_n = 1'b0; cpu_wr = 0; cpu_rd = 0; cpu_reg = 0; cpu_data = 0;
    ren_req = 0; ren_addr = 0;
    sync();
    chk_en = 1'b1;
    @(negedge clk_ppu);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_full", 32'(cpu_full), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    sync();
    rst_n = 1'b1;

    // basic address latch and write
    wr(3'd6, 8'h21); wr(3'd6, 8'h08); wr(3'd7, 8'h55);
    @(negedge clk_ppu);
    chk("w1_we", 32'(ram_we), 32'd1);
    chk("w1_addr", 32'(ram_addr), 32'h2108);
    chk("w1_data", 32'(ram_wdata), 32'h55);
    sync();

    // increment by 32 with 14-bit wrap, held off by renderer priority
    ren_req = 1'b1; ren_addr = 14'h0123;
    wr(3'd0, 8'h04); wr(3'd6, 8'h3F); wr(3'd6, 8'hF0);
    wr(3'd7, 8'hA1); ren_addr = 14'h0456;
    wr(3'd7, 8'hA2); ren_addr = 14'h1789;
    wr(3'd7, 8'hA3);
    ren_req = 1'b0;
    @(negedge clk_ppu);
    chk("hold_valid", 32'(ren_valid), 32'd1);
    chk("hold_data", 32'(ren_data), 32'(ram_mem[14'h1789]));
    chk("d1_addr", 32'(ram_addr), 32'h3FF0);
    @(negedge clk_ppu);
    chk("d2_addr", 32'(ram_addr), 32'h0010);
    @(negedge clk_ppu);
    chk("d3_addr", 32'(ram_addr), 32'h0030);
    chk("d3_data", 32'(ram_wdata), 32'hA3);
    @(negedge clk_ppu);
    chk("drained_idle", 32'(idle), 32'd1);
    sync();

    // overflow: 10 writes into a depth-8 queue
    wr(3'd0, 8'h00);
    ren_req = 1'b1;
    for (int i = 0; i < 10; i++) wr(3'd7, 8'(i));
    @(negedge clk_ppu);
    chk("ovf_full", 32'(cpu_full), 32'd1);
`ifdef VRAM_ARB_DROP_CNT_EN
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
`else
    chk("ovf_drop", 32'(drop_cnt), 32'd0);
`endif
    sync();
    ren_req = 1'b0;
    repeat (9) sync();

    // toggle cleared by status read
    wr(3'd6, 8'h12); rd2(); wr(3'd6, 8'h34); wr(3'd6, 8'h56); wr(3'd7, 8'hAA);
    @(negedge clk_ppu);
    chk("tog_addr", 32'(ram_addr), 32'h3456);
    sync();

    // reset with entries queued
    ren_req = 1'b1;
    for (int i = 0; i < 4; i++) wr(3'd7, 8'(8'hC0 + i));
    ren_req = 1'b0; rst_n = 1'b0;
    @(negedge clk_ppu);
    chk("rstq_we", 32'(ram_we), 32'd0);
    chk("rstq_addr", 32'(ram_addr), 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk_ppu);
    chk("rstq_idle", 32'(idle), 32'd1);
    chk("rstq_we2", 32'(ram_we), 32'd0);
    sync();
    wr(3'd7, 8'h77);
    @(negedge clk_ppu);
    chk("rstq_vaddr", 32'(ram_addr), 32'd0);
    sync();

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      ren_req  = ($urandom_range(0, 99) < 45);
      ren_addr = 14'($urandom);
      cpu_wr   = ($urandom_range(0, 99) < 35);
      cpu_rd   = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 5))
        0: cpu_reg = 3'd0;
        1: cpu_reg = 3'd6;
        2, 3: cpu_reg = 3'd7;
        4: cpu_reg = 3'd2;
        default: cpu_reg = 3'($urandom);
      endcase
      cpu_data = 8'($urandom);
      sync();
    end
    rst_n = 1'b1; cpu_wr = 0; cpu_rd = 0; ren_req = 0;
    repeat (12) sync();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
